// File: rtl/led_7seg_scan_ctrl_if.sv
// Bundle of control inputs and pin-level outputs for the 4-digit 7-segment scan controller.
interface led_7seg_scan_ctrl_if;
  logic        enable;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;
  logic        frame_tick;

  modport master (
    output enable, data_in, dp_in, blank_mask, lz_en,
    input  seg, dp, dig, frame_tick
  );

  modport slave (
    input  enable, data_in, dp_in, blank_mask, lz_en,
    output seg, dp, dig, frame_tick
  );
endinterface

// File: rtl/led_7seg_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit 7-segment display with inter-digit blanking
// and a per-frame shadow capture so no digit ever shows a half-updated value.
module led_7seg_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  led_7seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BLANK = 2'd1, S_ON = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_capture;

  logic [15:0] r_sh_data, w_sh_data_nxt;
  logic [3:0]  r_sh_dp, w_sh_dp_nxt;
  logic [3:0]  r_sh_mask, w_sh_mask_nxt;
  logic        r_sh_lz, w_sh_lz_nxt;

  logic [6:0] r_seg, w_seg_nxt;
  logic       r_dp, w_dp_nxt;
  logic [3:0] r_dig, w_dig_nxt;
  logic       r_tick, w_tick_nxt;

  logic [3:0] w_nib;
  logic       w_dark;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // Digit 0 is never zero-suppressed; digit n is suppressed only when it and every higher nibble are zero.
  function automatic logic lz_dark(input logic [15:0] data, input logic [1:0] idx);
    case (idx)
      2'd1:    lz_dark = (data[15:4] == 12'h000);
      2'd2:    lz_dark = (data[15:8] == 8'h00);
      2'd3:    lz_dark = (data[15:12] == 4'h0);
      default: lz_dark = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_sh_data <= 16'h0000;
      r_sh_dp   <= 4'h0;
      r_sh_mask <= 4'h0;
      r_sh_lz   <= 1'b0;
      r_seg     <= SEG_OFF;
      r_dp      <= DP_OFF;
      r_dig     <= DIG_OFF;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sh_data <= w_sh_data_nxt;
      r_sh_dp   <= w_sh_dp_nxt;
      r_sh_mask <= w_sh_mask_nxt;
      r_sh_lz   <= w_sh_lz_nxt;
      r_seg     <= w_seg_nxt;
      r_dp      <= w_dp_nxt;
      r_dig     <= w_dig_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = S_BLANK;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
        end
      end
      S_BLANK: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == BLANK_LAST) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ON: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == ON_LAST) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
          w_capture   = (r_idx == 2'd3);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_sh_data_nxt = w_capture ? bus.data_in    : r_sh_data;
  assign w_sh_dp_nxt   = w_capture ? bus.dp_in      : r_sh_dp;
  assign w_sh_mask_nxt = w_capture ? bus.blank_mask : r_sh_mask;
  assign w_sh_lz_nxt   = w_capture ? bus.lz_en      : r_sh_lz;

  // Outputs are decoded from the next state so the pins change on the same edge as the FSM.
  assign w_nib  = w_sh_data_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_dark = w_sh_mask_nxt[w_idx_nxt] | (w_sh_lz_nxt & lz_dark(w_sh_data_nxt, w_idx_nxt));

  always_comb begin
    w_seg_nxt  = SEG_OFF;
    w_dp_nxt   = DP_OFF;
    w_dig_nxt  = DIG_OFF;
    w_tick_nxt = w_capture;
    if (w_state_nxt == S_ON && !w_dark) begin
      w_seg_nxt = SEG_ACTIVE_LOW ? ~hex_decode(w_nib) : hex_decode(w_nib);
      w_dp_nxt  = SEG_ACTIVE_LOW ? ~w_sh_dp_nxt[w_idx_nxt] : w_sh_dp_nxt[w_idx_nxt];
      w_dig_nxt = DIG_ACTIVE_LOW ? ~(4'b0001 << w_idx_nxt) : (4'b0001 << w_idx_nxt);
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.dig        = r_dig;
  assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_led_7seg_scan_ctrl.sv
// Directed plus randomized bench for led_7seg_scan_ctrl against a frame-position reference model.
module tb_led_7seg_scan_ctrl;

  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic clk;
  logic reset;
  led_7seg_scan_ctrl_if bus_if ();

  led_7seg_scan_ctrl #(
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYCLES   (BLANK),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position within the running scan plus the frame's captured inputs.
  bit          m_run = 1'b0;
  int          m_p   = 0;
  logic [15:0] m_data = 16'h0;
  logic [3:0]  m_dp   = 4'h0;
  logic [3:0]  m_mask = 4'h0;
  logic        m_lz   = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic        e_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic capture();
    m_data = bus_if.data_in;
    m_dp   = bus_if.dp_in;
    m_mask = bus_if.blank_mask;
    m_lz   = bus_if.lz_en;
  endtask

  task automatic step();
    int n;
    int w;
    logic dark;
    logic [3:0] nib;
    @(posedge clk);
    if (reset) begin
      m_run = 1'b0;
      m_p   = 0;
    end else if (!m_run) begin
      if (bus_if.enable) begin
        m_run = 1'b1;
        m_p   = 0;
        capture();
      end
    end else if (!bus_if.enable) begin
      m_run = 1'b0;
      m_p   = 0;
    end else begin
      m_p++;
      if (m_p % FRAME == 0) capture();
    end
    e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_tick = 1'b0;
    if (m_run) begin
      e_tick = (m_p % FRAME == 0);
      n    = (m_p / SCAN_DIV) % 4;
      w    = m_p % SCAN_DIV;
      nib  = 4'((m_data >> (4 * n)) & 16'hF);
      dark = m_mask[n] || (m_lz && n >= 1 && (m_data >> (4 * n)) == 16'h0);
      if (w >= BLANK && !dark) begin
        e_seg = ~hex_tab[nib];
        e_dp  = ~m_dp[n];
        e_dig = ~(4'b0001 << n);
      end
    end
    #1;
    chk("seg", {25'h0, bus_if.seg}, {25'h0, e_seg});
    chk("dp", {31'h0, bus_if.dp}, {31'h0, e_dp});
    chk("dig", {28'h0, bus_if.dig}, {28'h0, e_dig});
    chk("frame_tick", {31'h0, bus_if.frame_tick}, {31'h0, e_tick});
    chk("dig_at_most_one", {31'h0, ($countones(~bus_if.dig) <= 1)}, 32'h1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_to(input int phase);
    int k;
    k = 0;
    while (!(m_run && (m_p % FRAME) == phase) && k < 200) begin
      step();
      k++;
    end
    chk("run_to_bound", {31'h0, (k < 200)}, 32'h1);
  endtask

  task automatic chk_pins(input string tag, input logic [6:0] s, input logic d, input logic [3:0] g);
    chk({tag, "_seg"}, {25'h0, bus_if.seg}, {25'h0, s});
    chk({tag, "_dp"}, {31'h0, bus_if.dp}, {31'h0, d});
    chk({tag, "_dig"}, {28'h0, bus_if.dig}, {28'h0, g});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus_if.enable     = 1'b0;
    bus_if.data_in    = 16'h0;
    bus_if.dp_in      = 4'h0;
    bus_if.blank_mask = 4'h0;
    bus_if.lz_en      = 1'b0;
    run(3);
    chk_pins("reset", 7'h7F, 1'b1, 4'hF);
    chk("reset_tick", {31'h0, bus_if.frame_tick}, 32'h0);
    reset = 1'b0;
    run(20);

    // Basic scan of 12AF
    bus_if.data_in = 16'h12AF;
    bus_if.enable  = 1'b1;
    step();
    chk("start_tick", {31'h0, bus_if.frame_tick}, 32'h1);
    run_to(2);  chk_pins("d0_F", 7'h0E, 1'b1, 4'hE);
    run_to(10); chk_pins("d1_A", 7'h08, 1'b1, 4'hD);
    run_to(18); chk_pins("d2_2", 7'h24, 1'b1, 4'hB);
    run_to(26); chk_pins("d3_1", 7'h79, 1'b1, 4'h7);
    run_to(0);
    chk("second_tick", {31'h0, bus_if.frame_tick}, 32'h1);

    // Tear-free: mid-frame change is held off until the next capture
    run_to(11);
    bus_if.data_in = 16'h3456;
    run_to(26); chk_pins("tear_old", 7'h79, 1'b1, 4'h7);
    run_to(2);  chk_pins("tear_new0", 7'h02, 1'b1, 4'hE);
    run_to(10); chk_pins("tear_new1", 7'h12, 1'b1, 4'hD);
    run_to(18); chk_pins("tear_new2", 7'h19, 1'b1, 4'hB);
    run_to(26); chk_pins("tear_new3", 7'h30, 1'b1, 4'h7);

    // Leading-zero suppression
    bus_if.lz_en   = 1'b1;
    bus_if.data_in = 16'h0050;
    run_to(0);
    run_to(2);  chk_pins("lz_d0", 7'h40, 1'b1, 4'hE);
    run_to(10); chk_pins("lz_d1", 7'h12, 1'b1, 4'hD);
    run_to(18); chk_pins("lz_d2", 7'h7F, 1'b1, 4'hF);
    run_to(26); chk_pins("lz_d3", 7'h7F, 1'b1, 4'hF);
    bus_if.data_in = 16'h0000;
    run_to(0);
    run_to(2);  chk_pins("lz0_d0", 7'h40, 1'b1, 4'hE);
    run_to(10); chk_pins("lz0_d1", 7'h7F, 1'b1, 4'hF);

    // Blank mask and decimal points
    bus_if.lz_en      = 1'b0;
    bus_if.blank_mask = 4'b0100;
    bus_if.dp_in      = 4'b0001;
    bus_if.data_in    = 16'h8888;
    run_to(0);
    run_to(2);  chk_pins("mask_d0", 7'h00, 1'b0, 4'hE);
    run_to(10); chk_pins("mask_d1", 7'h00, 1'b1, 4'hD);
    run_to(18); chk_pins("mask_d2", 7'h7F, 1'b1, 4'hF);
    run_to(26); chk_pins("mask_d3", 7'h00, 1'b1, 4'h7);

    // Abort mid digit-2 ON, then resume from digit 0
    bus_if.blank_mask = 4'b0000;
    run_to(0);
    run_to(19);
    bus_if.enable = 1'b0;
    step();
    chk_pins("abort", 7'h7F, 1'b1, 4'hF);
    run(3);
    bus_if.enable = 1'b1;
    step();
    chk("resume_tick", {31'h0, bus_if.frame_tick}, 32'h1);
    step();
    chk_pins("resume_blank", 7'h7F, 1'b1, 4'hF);
    step();
    chk_pins("resume_lit", 7'h00, 1'b0, 4'hE);

    // Asynchronous reset mid-ON
    run_to(5);
    #2;
    reset = 1'b1;
    #1;
    chk_pins("async_rst", 7'h7F, 1'b1, 4'hF);
    chk("async_rst_tick", {31'h0, bus_if.frame_tick}, 32'h0);
    m_run = 1'b0;
    m_p   = 0;
    run(2);
    reset = 1'b0;
    run(2);

    // Randomized inputs and enable toggling
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus_if.data_in    = 16'($urandom);
        bus_if.dp_in      = 4'($urandom);
        bus_if.blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        bus_if.lz_en      = 1'($urandom);
      end
      if (bus_if.enable && $urandom_range(0, 199) == 0) bus_if.enable = 1'b0;
      else if (!bus_if.enable && $urandom_range(0, 9) == 0) bus_if.enable = 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
